// File: rtl/komandara_rsp_router_if.sv
// rtl/komandara_rsp_router_if.sv - issue/response bundle between arbiter return path, downstream slave and requesters
interface komandara_rsp_router_if #(
  parameter int N_REQ  = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              issue_valid_i;
  logic [N_REQ-1:0]  issue_gnt_i;
  logic              issue_ready_o;
  logic              rsp_valid_i;
  logic [DATA_W-1:0] rsp_data_i;
  logic              rsp_err_i;
  logic              rsp_ready_o;
  logic [N_REQ-1:0]  rsp_valid_o;
  logic [N_REQ-1:0]  rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic [CNT_W-1:0]  outstanding_o;
  logic              unexp_rsp_o;

  modport slave (
    input  issue_valid_i, issue_gnt_i, rsp_valid_i, rsp_data_i, rsp_err_i, rsp_ready_i,
    output issue_ready_o, rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           outstanding_o, unexp_rsp_o
  );

  modport master (
    output issue_valid_i, issue_gnt_i, rsp_valid_i, rsp_data_i, rsp_err_i, rsp_ready_i,
    input  issue_ready_o, rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           outstanding_o, unexp_rsp_o
  );
endinterface

// File: rtl/komandara_rsp_router.sv
// rtl/komandara_rsp_router.sv - in-order response router steering downstream responses via a grant ID FIFO
module komandara_rsp_router #(
  parameter int N_REQ  = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  komandara_rsp_router_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             unexp_q;

  logic             empty, push, pop;
  logic [IDX_W-1:0] head, gnt_idx;
  logic             head_ready;

  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Descending scan so the lowest set grant bit wins.
  always_comb begin
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.issue_gnt_i[k]) gnt_idx = IDX_W'(k);
    end
  end

  always_comb begin
    head_ready      = 1'b0;
    bus.rsp_valid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDX_W'(k) == head) begin
        head_ready         = bus.rsp_ready_i[k];
        bus.rsp_valid_o[k] = bus.rsp_valid_i && !empty;
      end
    end
  end

  assign bus.issue_ready_o = (count_q != CNT_W'(DEPTH));
  assign bus.rsp_ready_o   = empty ? 1'b1 : head_ready;
  assign bus.rsp_data_o    = bus.rsp_data_i;
  assign bus.rsp_err_o     = bus.rsp_err_i;
  assign bus.outstanding_o = count_q;
  assign bus.unexp_rsp_o   = unexp_q;

  assign push = bus.issue_valid_i && bus.issue_ready_o && (|bus.issue_gnt_i);
  assign pop  = !empty && bus.rsp_valid_i && bus.rsp_ready_o;

  // Entries are left unreset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) fifo_q[wr_ptr_q] <= gnt_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      unexp_q  <= 1'b0;
    end else begin
      unexp_q <= empty && bus.rsp_valid_i;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_onehot_valid: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.rsp_valid_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && count_q == CNT_W'(DEPTH)));
  a_count_bound:  assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CNT_W'(DEPTH));
`endif
endmodule

// File: tb/tb_komandara_rsp_router.sv
// tb/tb_komandara_rsp_router.sv - scoreboard bench for komandara_rsp_router
module tb_komandara_rsp_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   mcount = 0;

  logic [1:0]  exp_id_q[$];
  logic [32:0] exp_data_q[$];

  komandara_rsp_router_if #(.N_REQ(4), .DEPTH(4), .DATA_W(32)) bus ();

  komandara_rsp_router #(.N_REQ(4), .DEPTH(4), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] low_idx(input logic [3:0] g);
    logic [1:0] r = 2'd0;
    for (int k = 3; k >= 0; k--) if (g[k]) r = 2'(k);
    return r;
  endfunction

  // Response monitor: every accepted response is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid_i && bus.rsp_ready_o) begin
      if (exp_data_q.size() != 0) begin
        logic [1:0]  id;
        logic [32:0] de;
        id = exp_id_q.pop_front();
        de = exp_data_q.pop_front();
        chk("route_valid", 32'(bus.rsp_valid_o), 32'(4'b0001 << id));
        chk("route_data", bus.rsp_data_o, de[31:0]);
        chk("route_err", 32'(bus.rsp_err_o), 32'(de[32]));
      end else begin
        chk("dropped_valid", 32'(bus.rsp_valid_o), 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    bus.issue_valid_i = 1'b0;
    bus.issue_gnt_i   = 4'b0;
    bus.rsp_valid_i   = 1'b0;
    bus.rsp_data_i    = 32'h0;
    bus.rsp_err_i     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    mcount = 0;
    exp_id_q.delete();
    exp_data_q.delete();
  endtask

  task automatic step(input logic iv, input logic [3:0] gnt, input logic rv,
                      input logic [31:0] d, input logic e);
    logic       do_pop, do_push, exp_unexp;
    logic [1:0] front;
    do_pop    = 1'b0;
    do_push   = 1'b0;
    front     = (exp_id_q.size() != 0) ? exp_id_q[0] : 2'd0;
    exp_unexp = rv && (mcount == 0);
    bus.issue_valid_i = iv;
    bus.issue_gnt_i   = gnt;
    bus.rsp_valid_i   = rv;
    bus.rsp_data_i    = d;
    bus.rsp_err_i     = e;
    if (rv && mcount != 0 && bus.rsp_ready_i[front]) begin
      do_pop = 1'b1;
      exp_data_q.push_back({e, d});
    end
    if (iv && gnt != 4'b0 && mcount < 4) begin
      do_push = 1'b1;
      exp_id_q.push_back(low_idx(gnt));
    end
    @(negedge clk);
    if (rv) begin
      if (mcount == 0) begin
        chk("empty_rsp_ready", 32'(bus.rsp_ready_o), 32'd1);
        chk("empty_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      end else begin
        chk("head_rsp_ready", 32'(bus.rsp_ready_o), 32'(bus.rsp_ready_i[front]));
        chk("head_rsp_valid", 32'(bus.rsp_valid_o), 32'(4'b0001 << front));
      end
    end
    @(posedge clk);
    #1;
    mcount = mcount + int'(do_push) - int'(do_pop);
    idle_inputs();
    chk("unexp_pulse", 32'(bus.unexp_rsp_o), 32'(exp_unexp));
    chk("outstanding_model", 32'(bus.outstanding_o), 32'(mcount));
    chk("issue_ready_model", 32'(bus.issue_ready_o), 32'(mcount != 4));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pair_gnt [6];
    pair_gnt = '{4'b0001, 4'b0110, 4'b1000, 4'b0010, 4'b0001, 4'b0100};
    idle_inputs();
    bus.rsp_ready_i = 4'b1111;

    do_reset(2);
    chk("rst_issue_ready", 32'(bus.issue_ready_o), 32'd1);
    chk("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_unexp", 32'(bus.unexp_rsp_o), 32'd0);

    // In-order routing
    step(1, 4'b0100, 0, 0, 0);
    step(1, 4'b0001, 0, 0, 0);
    step(1, 4'b1000, 0, 0, 0);
    chk("inorder_out3", 32'(bus.outstanding_o), 32'd3);
    step(0, 0, 1, 32'hA, 0);
    chk("inorder_out2", 32'(bus.outstanding_o), 32'd2);
    step(0, 0, 1, 32'hB, 0);
    chk("inorder_out1", 32'(bus.outstanding_o), 32'd1);
    step(0, 0, 1, 32'hC, 1);
    chk("inorder_out0", 32'(bus.outstanding_o), 32'd0);

    // Backpressure on requester 2; other readies must not matter
    step(1, 4'b0100, 0, 0, 0);
    step(1, 4'b0010, 0, 0, 0);
    bus.rsp_ready_i = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'hD, 0);
      chk("bp_hold", 32'(bus.outstanding_o), 32'd2);
    end
    bus.rsp_ready_i = 4'b0100;
    step(0, 0, 1, 32'hD, 0);
    chk("bp_release", 32'(bus.outstanding_o), 32'd1);
    bus.rsp_ready_i = 4'b1111;
    step(0, 0, 1, 32'hE, 0);
    chk("bp_drain", 32'(bus.outstanding_o), 32'd0);

    // Full, blocked issue, then wrap
    step(1, 4'b0001, 0, 0, 0);
    step(1, 4'b0010, 0, 0, 0);
    step(1, 4'b0100, 0, 0, 0);
    step(1, 4'b1000, 0, 0, 0);
    chk("full_out4", 32'(bus.outstanding_o), 32'd4);
    chk("full_not_ready", 32'(bus.issue_ready_o), 32'd0);
    step(1, 4'b0001, 0, 0, 0);
    chk("full_5th_dropped", 32'(bus.outstanding_o), 32'd4);
    step(1, 4'b0010, 1, 32'h10, 0);
    chk("full_pop_issue", 32'(bus.outstanding_o), 32'd3);
    for (int i = 0; i < 6; i++) step(1, pair_gnt[i], 1, 32'h20 + 32'(i), i[0]);
    chk("wrap_out3", 32'(bus.outstanding_o), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h30 + 32'(i), 0);
    chk("wrap_drain", 32'(bus.outstanding_o), 32'd0);

    // Unexpected response
    step(0, 0, 1, 32'h55, 1);
    chk("unexp_high", 32'(bus.unexp_rsp_o), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("unexp_low", 32'(bus.unexp_rsp_o), 32'd0);

    // Same-cycle push and response while empty, then mid-operation reset
    step(1, 4'b0010, 1, 32'h66, 0);
    chk("same_unexp", 32'(bus.unexp_rsp_o), 32'd1);
    chk("same_out1", 32'(bus.outstanding_o), 32'd1);
    step(1, 4'b0001, 0, 0, 0);
    step(1, 4'b1000, 0, 0, 0);
    chk("pre_rst_out3", 32'(bus.outstanding_o), 32'd3);
    do_reset(1);
    chk("mid_rst_out0", 32'(bus.outstanding_o), 32'd0);
    chk("mid_rst_ready", 32'(bus.issue_ready_o), 32'd1);
    step(0, 0, 1, 32'h77, 0);
    chk("post_rst_unexp", 32'(bus.unexp_rsp_o), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
